// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Byte-stream program loader for the instruction memory read by
//                the single-cycle datapath's fetch stage. Receives a 2-byte
//                big-endian word-count header followed by big-endian 32-bit
//                instruction words over a valid/ready handshake, writes each
//                word at byte addresses 0, 4, 8, ... and holds the CPU in reset
//                until the load has completed successfully.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W     : instruction-memory byte-address width (matches the PC)
//    MAX_WORDS  : largest accepted word count, must be <= 2**ADDR_W / 4
//  Ports
//    clk          in   system clock, rising edge
//    reset        in   synchronous active-high reset
//    start        in   one-cycle pulse that begins a load session
//    rx_data      in   incoming byte
//    rx_valid     in   rx_data is valid
//    rx_ready     out  loader accepts a byte this cycle
//    mem_we       out  instruction-memory write strobe (one cycle per word)
//    mem_addr     out  byte address of the word being written
//    mem_wdata    out  assembled instruction word
//    cpu_reset    out  PC/datapath reset, high while no program is loaded
//    busy         out  load session in progress
//    done         out  last load succeeded (sticky)
//    error        out  last load failed (sticky)
//    words_loaded out  words written in the current or last session
//  Build option
//    IMEM_LOADER_CHECKSUM_EN : when defined, a trailing checksum byte (XOR of
//                              all data bytes) is required after the last word.
// ============================================================================
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_FIN    = 3'd5,
        S_ERR    = 3'd6,
        S_CHK    = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_FIN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;
`endif

    state_t              state_q;
    logic                rx_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                cpu_reset_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [ADDR_W-1:0]   words_q;
    logic [15:0]         count_q;
    logic [1:0]          byte_cnt_q;
    // Only the first three bytes of a word need storing; the fourth arrives
    // on the cycle the word is committed to mem_wdata.
    logic [23:0]         shift_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    // Next-state helpers shared by several FSM branches.
    logic                xfer_d;
    logic [15:0]         count_d;
    logic [ADDR_W-1:0]   words_d;
    logic                last_word_d;

    assign xfer_d      = rx_valid && rx_ready_q;
    assign count_d     = {count_q[15:8], rx_data};
    assign words_d     = words_q + 1'b1;
    assign last_word_d = (16'(words_d) == count_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
            count_q     <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        words_q     <= '0;
                        mem_addr_q  <= '0;
                        busy_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        byte_cnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q      <= '0;
`endif
                        rx_ready_q  <= 1'b1;
                        state_q     <= S_CNT_HI;
                    end
                end

                S_CNT_HI: begin
                    if (xfer_d) begin
                        count_q[15:8] <= rx_data;
                        state_q       <= S_CNT_LO;
                    end
                end

                S_CNT_LO: begin
                    if (xfer_d) begin
                        count_q[7:0] <= rx_data;
                        // Decide on the full count including the byte
                        // arriving this cycle.
                        if (count_d == 16'd0) begin
                            rx_ready_q <= 1'b0;
                            state_q    <= S_FIN;
                        end else if (count_d > MAX_CNT) begin
                            rx_ready_q <= 1'b0;
                            state_q    <= S_ERR;
                        end else begin
                            state_q    <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer_d) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        shift_q    <= {shift_q[15:0], rx_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ rx_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            mem_wdata_q <= {shift_q, rx_data};
                            mem_we_q    <= 1'b1;
                            rx_ready_q  <= 1'b0;
                            state_q     <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= mem_addr_q + ADDR_W'(4);
                    words_q    <= words_d;
                    if (last_word_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        rx_ready_q <= 1'b1;
                        state_q    <= S_CHK;
`else
                        state_q    <= S_FIN;
`endif
                    end else begin
                        rx_ready_q <= 1'b1;
                        state_q    <= S_DATA;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer_d) begin
                        rx_ready_q <= 1'b0;
                        state_q    <= (rx_data == csum_q) ? S_FIN : S_ERR;
                    end
                end
`endif

                S_FIN: begin
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    cpu_reset_q <= 1'b0;
                    state_q     <= S_IDLE;
                end

                S_ERR: begin
                    // cpu_reset is left asserted: the program is incomplete.
                    busy_q      <= 1'b0;
                    error_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    rx_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
`default_nettype wire
